// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared types and widths for the DDR channel arbiter
package ddr_arb_pkg;

  localparam int DDR_INDEX_W = 19;
  localparam int DDR_LINE_W  = 512;
  localparam int DDR_WORD_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_PC,
    OWN_LOAD,
    OWN_STORE
  } owner_t;

endpackage

// File: rtl/ddr_arb_picker.sv
// rtl/ddr_arb_picker.sv - fixed-priority winner select with fetch anti-starvation counter
module ddr_arb_picker
  import ddr_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   pc_valid,
  input  logic   load_valid,
  input  logic   store_valid,
  input  logic   grant,
  output logic   any_valid,
  output owner_t winner
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_count;
  logic          starved;

  assign starved = (starve_count == CW'(STARVE_LIMIT));

  always_comb begin
    any_valid = pc_valid | load_valid | store_valid;
    winner    = OWN_PC;
    if (pc_valid && starved) begin
      winner = OWN_PC;
    end else if (store_valid) begin
      winner = OWN_STORE;
    end else if (load_valid) begin
      winner = OWN_LOAD;
    end
  end

  // Counts only grants lost by a waiting fetch; saturates so priority stays promoted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_count <= '0;
    end else if (!pc_valid) begin
      starve_count <= '0;
    end else if (grant) begin
      if (winner == OWN_PC) begin
        starve_count <= '0;
      end else if (!starved) begin
        starve_count <= starve_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ddr_channel_arbiter.sv
// rtl/ddr_channel_arbiter.sv - single-outstanding DDR arbiter for fetch, load and store
module ddr_channel_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pc_index_valid,
  input  logic [DDR_INDEX_W-1:0] pc_index,
  output logic                   pc_operation_done,
  output logic [DDR_LINE_W-1:0]  pc_read_inst,
  input  logic                   opload_index_valid,
  input  logic [DDR_INDEX_W-1:0] opload_index,
  output logic                   opload_operation_done,
  output logic [DDR_WORD_W-1:0]  opload_read_data,
  input  logic                   opstore_index_valid,
  input  logic [DDR_INDEX_W-1:0] opstore_index,
  input  logic [DDR_WORD_W-1:0]  opstore_write_mask,
  input  logic [DDR_WORD_W-1:0]  opstore_write_data,
  output logic                   opstore_operation_done,
  output logic                   ddr_chip_enable,
  output logic [DDR_INDEX_W-1:0] ddr_index,
  output logic                   ddr_write_enable,
  output logic                   ddr_burst_mode,
  output logic [DDR_WORD_W-1:0]  ddr_opstore_write_mask,
  output logic [DDR_WORD_W-1:0]  ddr_opstore_write_data,
  input  logic [DDR_WORD_W-1:0]  ddr_opload_read_data,
  input  logic [DDR_LINE_W-1:0]  ddr_pc_read_inst,
  input  logic                   ddr_operation_done,
  input  logic                   ddr_ready
);

  state_t                 state;
  owner_t                 owner;
  owner_t                 winner;
  logic                   any_valid;
  logic                   grant;
  logic [DDR_INDEX_W-1:0] sel_index;

  assign grant = (state == ST_IDLE) && ddr_ready && any_valid;

  ddr_arb_picker #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_picker (
    .clock      (clock),
    .reset_n    (reset_n),
    .pc_valid   (pc_index_valid),
    .load_valid (opload_index_valid),
    .store_valid(opstore_index_valid),
    .grant      (grant),
    .any_valid  (any_valid),
    .winner     (winner)
  );

  always_comb begin
    sel_index = pc_index;
    case (winner)
      OWN_LOAD:  sel_index = opload_index;
      OWN_STORE: sel_index = opstore_index;
      default:   sel_index = pc_index;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= ST_IDLE;
      owner                  <= OWN_PC;
      ddr_chip_enable        <= 1'b0;
      ddr_index              <= '0;
      ddr_write_enable       <= 1'b0;
      ddr_burst_mode         <= 1'b0;
      ddr_opstore_write_mask <= '0;
      ddr_opstore_write_data <= '0;
      pc_operation_done      <= 1'b0;
      opload_operation_done  <= 1'b0;
      opstore_operation_done <= 1'b0;
      pc_read_inst           <= '0;
      opload_read_data       <= '0;
    end else begin
      ddr_chip_enable        <= 1'b0;
      pc_operation_done      <= 1'b0;
      opload_operation_done  <= 1'b0;
      opstore_operation_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner                  <= winner;
            ddr_chip_enable        <= 1'b1;
            ddr_index              <= sel_index;
            ddr_write_enable       <= (winner == OWN_STORE);
            ddr_burst_mode         <= (winner == OWN_PC);
            ddr_opstore_write_mask <= (winner == OWN_STORE) ? opstore_write_mask : '0;
            ddr_opstore_write_data <= (winner == OWN_STORE) ? opstore_write_data : '0;
            state                  <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        // The ddr_* bus stays frozen here; only the completion pulse moves us on.
        ST_WAIT: begin
          if (ddr_operation_done) begin
            case (owner)
              OWN_LOAD: begin
                opload_read_data      <= ddr_opload_read_data;
                opload_operation_done <= 1'b1;
              end
              OWN_STORE: opstore_operation_done <= 1'b1;
              default: begin
                pc_read_inst      <= ddr_pc_read_inst;
                pc_operation_done <= 1'b1;
              end
            endcase
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_channel_arbiter.sv
// tb/tb_ddr_channel_arbiter.sv - directed vector bench for ddr_channel_arbiter
module tb_ddr_channel_arbiter;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         pc_index_valid;
  logic [18:0]  pc_index;
  logic         pc_operation_done;
  logic [511:0] pc_read_inst;
  logic         opload_index_valid;
  logic [18:0]  opload_index;
  logic         opload_operation_done;
  logic [63:0]  opload_read_data;
  logic         opstore_index_valid;
  logic [18:0]  opstore_index;
  logic [63:0]  opstore_write_mask;
  logic [63:0]  opstore_write_data;
  logic         opstore_operation_done;
  logic         ddr_chip_enable;
  logic [18:0]  ddr_index;
  logic         ddr_write_enable;
  logic         ddr_burst_mode;
  logic [63:0]  ddr_opstore_write_mask;
  logic [63:0]  ddr_opstore_write_data;
  logic [63:0]  ddr_opload_read_data;
  logic [511:0] ddr_pc_read_inst;
  logic         ddr_operation_done;
  logic         ddr_ready;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0]  exp_load = '0;
  logic [511:0] exp_line = '0;

  always #5 clock = ~clock;

  ddr_channel_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .pc_index_valid(pc_index_valid), .pc_index(pc_index),
    .pc_operation_done(pc_operation_done), .pc_read_inst(pc_read_inst),
    .opload_index_valid(opload_index_valid), .opload_index(opload_index),
    .opload_operation_done(opload_operation_done), .opload_read_data(opload_read_data),
    .opstore_index_valid(opstore_index_valid), .opstore_index(opstore_index),
    .opstore_write_mask(opstore_write_mask), .opstore_write_data(opstore_write_data),
    .opstore_operation_done(opstore_operation_done),
    .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index),
    .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
    .ddr_opstore_write_mask(ddr_opstore_write_mask),
    .ddr_opstore_write_data(ddr_opstore_write_data),
    .ddr_opload_read_data(ddr_opload_read_data), .ddr_pc_read_inst(ddr_pc_read_inst),
    .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready)
  );

  typedef struct {
    int          kind;       // 0 fetch, 1 load, 2 store
    logic [18:0] idx;
    logic [63:0] mask;
    logic [63:0] wdata;
    logic [63:0] rword;
    int          lat;
    logic        exp_we;
    logic        exp_burst;
  } vec_t;

  function automatic logic [511:0] mk_line(input logic [63:0] w);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = w + 64'(i);
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {ddr_chip_enable, ddr_write_enable, ddr_burst_mode, ddr_index,
          pc_operation_done, opload_operation_done, opstore_operation_done}, '0);
    check({name, "_wr"}, {ddr_opstore_write_mask, ddr_opstore_write_data}, '0);
    check({name, "_ld"}, opload_read_data, '0);
    check({name, "_pc"}, pc_read_inst, '0);
  endtask

  task automatic serve(input int kind, input int lat, input logic [63:0] rword,
                       input logic exp_we, input logic exp_burst, input string tag,
                       output int en_wait);
    logic [18:0] eidx;
    bit found = 0;
    en_wait = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (ddr_chip_enable) begin
        en_wait = i;
        found = 1;
        break;
      end
    end
    if (!found) begin
      check({tag, "_enable_timeout"}, 0, 1);
      return;
    end
    eidx = (kind == 0) ? pc_index : (kind == 1) ? opload_index : opstore_index;
    check({tag, "_index"}, ddr_index, eidx);
    check({tag, "_we_burst"}, {ddr_write_enable, ddr_burst_mode}, {exp_we, exp_burst});
    check({tag, "_mask"}, ddr_opstore_write_mask, (kind == 2) ? opstore_write_mask : 64'd0);
    check({tag, "_wdata"}, ddr_opstore_write_data, (kind == 2) ? opstore_write_data : 64'd0);
    repeat (lat - 1) @(negedge clock);
    check({tag, "_hold"}, {ddr_chip_enable, ddr_index, ddr_write_enable}, {1'b0, eidx, exp_we});
    ddr_opload_read_data = rword;
    ddr_pc_read_inst     = mk_line(rword);
    ddr_operation_done   = 1'b1;
    @(negedge clock);
    ddr_operation_done = 1'b0;
    if (kind == 1) exp_load = rword;
    if (kind == 0) exp_line = mk_line(rword);
    check({tag, "_done"}, {pc_operation_done, opload_operation_done, opstore_operation_done},
          {kind == 0, kind == 1, kind == 2});
    check({tag, "_ld_data"}, opload_read_data, exp_load);
    check({tag, "_pc_data"}, pc_read_inst, exp_line);
    if (kind == 0) pc_index_valid = 1'b0;
    if (kind == 1) opload_index_valid = 1'b0;
    if (kind == 2) opstore_index_valid = 1'b0;
    @(negedge clock);
    check({tag, "_done_clear"}, {pc_operation_done, opload_operation_done, opstore_operation_done}, '0);
  endtask

  vec_t tbl[6];
  int   w;
  logic seen;

  initial begin
    tbl[0] = '{1, 19'h00010, 64'h0, 64'h0, 64'h00000000DEADBEEF, 3, 1'b0, 1'b0};
    tbl[1] = '{2, 19'h12345, 64'hFFFF0000FFFF0000, 64'h0123456789ABCDEF, 64'h1111, 2, 1'b1, 1'b0};
    tbl[2] = '{0, 19'h7FFFF, 64'h0, 64'h0, 64'hA5A5A5A5A5A5A5A5, 4, 1'b0, 1'b1};
    tbl[3] = '{1, 19'h00000, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 2, 1'b0, 1'b0};
    tbl[4] = '{2, 19'h00001, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h2222, 5, 1'b1, 1'b0};
    tbl[5] = '{0, 19'h40000, 64'h0, 64'h0, 64'h0000000000000001, 2, 1'b0, 1'b1};

    reset_n = 1'b0;
    pc_index_valid = 0; pc_index = '0;
    opload_index_valid = 0; opload_index = '0;
    opstore_index_valid = 0; opstore_index = '0;
    opstore_write_mask = '0; opstore_write_data = '0;
    ddr_opload_read_data = '0; ddr_pc_read_inst = '0;
    ddr_operation_done = 0; ddr_ready = 1;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // single-requester table
    for (int i = 0; i < 6; i++) begin
      case (tbl[i].kind)
        0: begin pc_index = tbl[i].idx; pc_index_valid = 1'b1; end
        1: begin opload_index = tbl[i].idx; opload_index_valid = 1'b1; end
        default: begin
          opstore_index = tbl[i].idx; opstore_write_mask = tbl[i].mask;
          opstore_write_data = tbl[i].wdata; opstore_index_valid = 1'b1;
        end
      endcase
      serve(tbl[i].kind, tbl[i].lat, tbl[i].rword, tbl[i].exp_we, tbl[i].exp_burst,
            $sformatf("vec%0d", i), w);
      check($sformatf("vec%0d_latency", i), w, 1);
    end

    // all three requesters at once
    pc_index = 19'h00ABC; opload_index = 19'h00DEF; opstore_index = 19'h01234;
    opstore_write_mask = 64'h00000000FFFFFFFF; opstore_write_data = 64'hCAFEF00D12345678;
    pc_index_valid = 1; opload_index_valid = 1; opstore_index_valid = 1;
    serve(2, 2, 64'h3333, 1'b1, 1'b0, "prio_store", w);
    check("prio_store_latency", w, 1);
    serve(1, 2, 64'h4444, 1'b0, 1'b0, "prio_load", w);
    serve(0, 2, 64'h5555, 1'b0, 1'b1, "prio_fetch", w);

    // fetch starvation with store and load always re-requesting
    pc_index = 19'h00F00; pc_index_valid = 1;
    opload_index_valid = 1; opstore_index_valid = 1;
    for (int g = 0; g < 4; g++) begin
      serve(2, 2, 64'(g), 1'b1, 1'b0, $sformatf("starve_grant%0d", g), w);
      opstore_index = opstore_index + 19'd1;
      opstore_index_valid = 1;
    end
    serve(0, 2, 64'h6666, 1'b0, 1'b1, "starve_fetch", w);
    opstore_index_valid = 0; opload_index_valid = 0;
    @(negedge clock);

    // ddr_ready held low blocks issue
    ddr_ready = 0; opload_index = 19'h00077; opload_index_valid = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      seen |= ddr_chip_enable;
    end
    check("ready_low_no_enable", seen, 0);
    ddr_ready = 1;
    serve(1, 2, 64'h7777, 1'b0, 1'b0, "ready_rise", w);
    check("ready_rise_latency", w, 1);

    // reset mid-operation abandons the access
    opload_index = 19'h2AAAA; opload_index_valid = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = ddr_chip_enable;
    end
    check("rst_enable_seen", seen, 1);
    @(negedge clock);
    reset_n = 0; opload_index_valid = 0;
    @(negedge clock);
    check_all_zero("rst_mid");
    ddr_opload_read_data = 64'h9999; ddr_pc_read_inst = mk_line(64'h9999);
    ddr_operation_done = 1;
    @(negedge clock);
    ddr_operation_done = 0; reset_n = 1;
    exp_load = '0; exp_line = '0;
    seen = 0;
    repeat (3) begin
      @(negedge clock);
      seen |= pc_operation_done | opload_operation_done | opstore_operation_done;
    end
    check("rst_no_done", seen, 0);
    check_all_zero("rst_after");
    opload_index = 19'h00005; opload_index_valid = 1;
    serve(1, 2, 64'h0BADC0DE, 1'b0, 1'b0, "post_rst", w);
    check("post_rst_latency", w, 1);

    // spurious completion while idle
    ddr_opload_read_data = 64'hFEEDFACE; ddr_pc_read_inst = mk_line(64'hFEEDFACE);
    ddr_operation_done = 1;
    @(negedge clock);
    ddr_operation_done = 0;
    seen = 0;
    repeat (2) begin
      @(negedge clock);
      seen |= pc_operation_done | opload_operation_done | opstore_operation_done | ddr_chip_enable;
    end
    check("spurious_no_done", seen, 0);
    check("spurious_ld_data", opload_read_data, exp_load);
    check("spurious_pc_data", pc_read_inst, exp_line);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr_channel_arbiter.md
DDR_CHANNEL_ARBITER -- requirements
Module: ddr_channel_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, consecutive lost arbitrations after which fetch is promoted to top priority.
REQ-002 clock  input  1  sole clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 pc_index_valid  input  1  fetch burst-read request, held until pc_operation_done.
REQ-005 pc_index  input  19  fetch line index, stable while valid.
REQ-006 pc_operation_done  output  1  one-cycle pulse, fetch complete.
REQ-007 pc_read_inst  output  512  fetched line, valid with done, held until next fetch completes.
REQ-008 opload_index_valid  input  1  load read request, held until opload_operation_done.
REQ-009 opload_index  input  19  load index, stable while valid.
REQ-010 opload_operation_done  output  1  one-cycle pulse, load complete.
REQ-011 opload_read_data  output  64  load data, valid with done, held until next load completes.
REQ-012 opstore_index_valid  input  1  store request, held until opstore_operation_done.
REQ-013 opstore_index  input  19  store index, stable while valid.
REQ-014 opstore_write_mask  input  64  store bit mask, stable while valid.
REQ-015 opstore_write_data  input  64  store data, stable while valid.
REQ-016 opstore_operation_done  output  1  one-cycle pulse, store complete.
REQ-017 ddr_chip_enable  output  1  one-cycle operation start pulse to DDR model.
REQ-018 ddr_index  output  19  granted index, held from issue through completion.
REQ-019 ddr_write_enable  output  1  1 for store, 0 for reads.
REQ-020 ddr_burst_mode  output  1  1 only for fetch grant.
REQ-021 ddr_opstore_write_mask  output  64  latched store mask; 0 for non-store grants.
REQ-022 ddr_opstore_write_data  output  64  latched store data; 0 for non-store grants.
REQ-023 ddr_opload_read_data  input  64  DDR load data, sampled on ddr_operation_done.
REQ-024 ddr_pc_read_inst  input  512  DDR burst data, sampled on ddr_operation_done.
REQ-025 ddr_operation_done  input  1  DDR completion pulse.
REQ-026 ddr_ready  input  1  DDR accepts a new operation.

Function
REQ-027 FSM states IDLE, ISSUE, WAIT, DONE; exactly one DDR operation outstanding at any time.
REQ-028 IDLE: if ddr_ready=1 and any valid, latch winner (owner, index, we, burst, mask, data) and go ISSUE; ddr_ready=0 or no valid -> stay IDLE, no grant.
REQ-029 ISSUE: ddr_chip_enable=1 for exactly this cycle, unconditionally go WAIT; request-to-enable latency one cycle.
REQ-030 WAIT: on ddr_operation_done capture ddr_opload_read_data (load owner) or ddr_pc_read_inst (fetch owner) and go DONE; otherwise hold all ddr_* outputs stable.
REQ-031 DONE: pulse owner's *_operation_done for one cycle, data outputs already updated; next state IDLE.
REQ-032 Requesters drop valid on the edge at which done is sampled; arbiter never regrants a completed request.
REQ-033 Priority: store > load > fetch, except fetch is highest when starve counter == STARVE_LIMIT.
REQ-034 Starve counter: increments (saturating at STARVE_LIMIT) per grant to another requester while pc_index_valid=1; clears on fetch grant or pc_index_valid=0.
REQ-035 ddr_operation_done outside WAIT ignored; valid changes on non-granted channels during an operation only affect next IDLE arbitration.
REQ-036 Store completion leaves opload_read_data and pc_read_inst unchanged.

Reset
REQ-037 reset_n=0: state IDLE, starve counter 0, all outputs 0 (including read-data outputs); asserted mid-operation, the outstanding DDR operation is abandoned and no done pulse follows.

Structure
REQ-038 Package ddr_arb_pkg holds state enum, owner enum {OWN_PC, OWN_LOAD, OWN_STORE}, DDR_INDEX_W=19, DDR_LINE_W=512, DDR_WORD_W=64.
REQ-039 Winner select plus starve counter forms sub-module ddr_arb_picker; FSM and datapath latches stay in top.

Verification
REQ-040 Single load idx 0x00010, DDR done 3 cycles after enable with data 0xDEADBEEF -> enable 1 cycle after valid, opload_operation_done 1 cycle after DDR done, data 0xDEADBEEF, write_enable=0, burst=0.
REQ-041 Store+load+fetch valid same cycle -> grant order store, load, fetch; store cycle shows write_enable=1, mask/data forwarded; fetch shows burst_mode=1.
REQ-042 Fetch held valid, stores+loads continuously re-requested, STARVE_LIMIT=4 -> fetch granted on 5th arbitration.
REQ-043 ddr_ready=0 for 10 cycles with load valid -> no chip_enable; ddr_ready rises -> enable next cycle.
REQ-044 reset_n low during WAIT, then DDR done pulses -> no done output, state IDLE, all outputs 0.
REQ-045 Spurious ddr_operation_done in IDLE -> no done pulse, read-data outputs unchanged.
